// File: rtl/distribute_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : distribute_sequencer
// Description : Layer-level controller for the activation/weight distribution
//               stage. Layer descriptors enter a 2-entry FIFO; each valid
//               descriptor produces one configure pulse to the distribute-in
//               and distribute-out blocks. Completed output transfers are then
//               counted down to the end of the layer. A fixed drain interval
//               follows, then layer completion is signalled and the next
//               descriptor is launched.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                    : clock
//   rst                    : asynchronous reset, active low
//   desc_data_in           : descriptor {mode, num_iters, num_reads_per_iter}
//   desc_valid_in          : descriptor write strobe
//   desc_avail_out         : descriptor FIFO can accept an entry
//   configure_out          : one-cycle configure pulse
//   conf_mode_out          : mode of the current layer
//   num_iters_out          : iterations of the current layer
//   num_reads_per_iter_out : reads per iteration of the current layer
//   xfer_in                : one pulse per performed distribution read
//   busy_out               : a layer is being configured, run or drained
//   layer_done_out         : one-cycle pulse when a layer completes
//   desc_error_out         : one-cycle pulse when a zero-count descriptor
//                            is discarded
//   layers_done_out        : completed-layer counter (wraps)
// ============================================================================
module distribute_sequencer #(
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int DRAIN_CYCLES           = 4,
  localparam int DESC_WIDTH            = 1 + LOG_MAX_ITERS + LOG_MAX_READS_PER_ITER
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DESC_WIDTH-1:0]             desc_data_in,
  input  logic                              desc_valid_in,
  output logic                              desc_avail_out,
  output logic                              configure_out,
  output logic                              conf_mode_out,
  output logic [LOG_MAX_ITERS-1:0]          num_iters_out,
  output logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter_out,
  input  logic                              xfer_in,
  output logic                              busy_out,
  output logic                              layer_done_out,
  output logic                              desc_error_out,
  output logic [15:0]                       layers_done_out
);

  // Remaining-transfer counter holds the full iters*reads product.
  localparam int         c_REM_W = LOG_MAX_ITERS + LOG_MAX_READS_PER_ITER;
  localparam logic [7:0] c_DRAIN = 8'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONFIG = 2'd1,
    S_RUN    = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Descriptor FIFO (2 entries)
  // --------------------------------------------------------------------------
  logic [DESC_WIDTH-1:0] r_fifo_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_fifo_cnt;

  logic                              w_full;
  logic                              w_empty;
  logic                              w_push;
  logic                              w_pop;
  logic [DESC_WIDTH-1:0]             w_head;
  logic                              w_head_mode;
  logic [LOG_MAX_ITERS-1:0]          w_head_iters;
  logic [LOG_MAX_READS_PER_ITER-1:0] w_head_reads;
  logic                              w_head_bad;
  logic [c_REM_W-1:0]                w_head_product;

  state_t             r_state;
  logic [c_REM_W-1:0] r_remaining;
  logic [7:0]         r_drain;

  assign w_full  = (r_fifo_cnt == 2'd2);
  assign w_empty = (r_fifo_cnt == 2'd0);

  // Writes while full are dropped; a write and a pop in the same cycle are
  // both honoured (only possible when not full).
  assign w_push = desc_valid_in & ~w_full;

  // IDLE consumes the head every cycle it is present, whether it launches a
  // layer or is discarded as a zero-count descriptor.
  assign w_pop = (r_state == S_IDLE) & ~w_empty;

  assign desc_avail_out = ~w_full;

  assign w_head       = r_fifo_mem[r_rd_ptr];
  assign w_head_mode  = w_head[DESC_WIDTH-1];
  assign w_head_iters = w_head[DESC_WIDTH-2 -: LOG_MAX_ITERS];
  assign w_head_reads = w_head[LOG_MAX_READS_PER_ITER-1:0];
  assign w_head_bad   = (w_head_iters == '0) | (w_head_reads == '0);

  // Product width equals the sum of the operand widths, so it cannot overflow.
  assign w_head_product = c_REM_W'(w_head_iters) * c_REM_W'(w_head_reads);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fifo_mem[0] <= '0;
      r_fifo_mem[1] <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_fifo_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_mem[r_wr_ptr] <= desc_data_in;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Layer sequencing FSM with registered outputs
  // --------------------------------------------------------------------------
  // layer_done_out is raised in the DRAIN cycle whose count value is 1, i.e.
  // DRAIN_CYCLES cycles after the final transfer. Being registered, it is set
  // on the transition into that cycle: either straight from RUN (when the
  // drain interval is one cycle) or when the count steps from 2 to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state                <= S_IDLE;
      r_remaining            <= '0;
      r_drain                <= 8'd0;
      configure_out          <= 1'b0;
      conf_mode_out          <= 1'b0;
      num_iters_out          <= '0;
      num_reads_per_iter_out <= '0;
      busy_out               <= 1'b0;
      layer_done_out         <= 1'b0;
      desc_error_out         <= 1'b0;
      layers_done_out        <= 16'd0;
    end else begin
      configure_out  <= 1'b0;
      layer_done_out <= 1'b0;
      desc_error_out <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            if (w_head_bad) begin
              desc_error_out <= 1'b1;
            end else begin
              conf_mode_out          <= w_head_mode;
              num_iters_out          <= w_head_iters;
              num_reads_per_iter_out <= w_head_reads;
              r_remaining            <= w_head_product;
              configure_out          <= 1'b1;
              busy_out               <= 1'b1;
              r_state                <= S_CONFIG;
            end
          end
        end

        // Single configure cycle; transfers seen here are not counted.
        S_CONFIG: begin
          r_state <= S_RUN;
        end

        S_RUN: begin
          if (xfer_in) begin
            r_remaining <= r_remaining - c_REM_W'(1);
            if (r_remaining == c_REM_W'(1)) begin
              r_drain <= c_DRAIN;
              r_state <= S_DRAIN;
              if (c_DRAIN == 8'd1) begin
                layer_done_out  <= 1'b1;
                layers_done_out <= layers_done_out + 16'd1;
              end
            end
          end
        end

        S_DRAIN: begin
          if (r_drain == 8'd1) begin
            busy_out <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_drain <= r_drain - 8'd1;
            if (r_drain == 8'd2) begin
              layer_done_out  <= 1'b1;
              layers_done_out <= layers_done_out + 16'd1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_distribute_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_distribute_sequencer
// Description : Self-checking bench for distribute_sequencer. Expected values
//               come from the descriptor rules: configure two cycles after a
//               write into an empty FIFO, iters*reads transfers per layer,
//               completion DRAIN_CYCLES after the last transfer, a 2-deep
//               descriptor queue, zero-count descriptors discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_distribute_sequencer;

  localparam int LI = 16;
  localparam int LR = 16;
  localparam int DC = 4;
  localparam int DW = 1 + LI + LR;

  typedef struct {
    logic          m;
    logic [LI-1:0] i;
    logic [LR-1:0] r;
  } desc_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] desc_data_in = '0;
  logic          desc_valid_in = 1'b0;
  logic          desc_avail_out;
  logic          configure_out;
  logic          conf_mode_out;
  logic [LI-1:0] num_iters_out;
  logic [LR-1:0] num_reads_per_iter_out;
  logic          xfer_in = 1'b0;
  logic          busy_out;
  logic          layer_done_out;
  logic          desc_error_out;
  logic [15:0]   layers_done_out;

  int errors = 0;
  int checks = 0;
  int exp_layers = 0;
  desc_t q[$];

  distribute_sequencer #(
    .LOG_MAX_ITERS         (LI),
    .LOG_MAX_READS_PER_ITER(LR),
    .DRAIN_CYCLES          (DC)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .desc_data_in          (desc_data_in),
    .desc_valid_in         (desc_valid_in),
    .desc_avail_out        (desc_avail_out),
    .configure_out         (configure_out),
    .conf_mode_out         (conf_mode_out),
    .num_iters_out         (num_iters_out),
    .num_reads_per_iter_out(num_reads_per_iter_out),
    .xfer_in               (xfer_in),
    .busy_out              (busy_out),
    .layer_done_out        (layer_done_out),
    .desc_error_out        (desc_error_out),
    .layers_done_out       (layers_done_out)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_desc(input logic m, input logic [LI-1:0] i, input logic [LR-1:0] r);
    desc_data_in  = {m, i, r};
    desc_valid_in = 1'b1;
    tick();
    desc_valid_in = 1'b0;
  endtask

  task automatic chk_fields(input string tag, input logic m, input logic [LI-1:0] i,
                            input logic [LR-1:0] r);
    chk({tag, "_mode"},  32'(conf_mode_out), 32'(m));
    chk({tag, "_iters"}, 32'(num_iters_out), 32'(i));
    chk({tag, "_reads"}, 32'(num_reads_per_iter_out), 32'(r));
  endtask

  // Write into an empty FIFO with the FSM idle; returns in the first RUN cycle.
  task automatic launch(input string tag, input logic m, input logic [LI-1:0] i,
                        input logic [LR-1:0] r);
    write_desc(m, i, r);
    chk({tag, "_cfg_early"}, 32'(configure_out), 32'd0);
    tick();
    chk({tag, "_cfg"}, 32'(configure_out), 32'd1);
    chk({tag, "_busy"}, 32'(busy_out), 32'd1);
    chk_fields(tag, m, i, r);
    tick();
  endtask

  // Issue n transfers starting in the current cycle; ends one cycle after the last.
  task automatic do_xfers(input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          xfer_in = 1'b0;
          tick();
          chk("early_done_gap", 32'(layer_done_out), 32'd0);
        end
      end
      xfer_in = 1'b1;
      tick();
      if (k != n - 1) chk("early_done", 32'(layer_done_out), 32'd0);
    end
    xfer_in = 1'b0;
  endtask

  // Called one cycle after the last transfer; returns in cycle M+1.
  task automatic expect_done();
    for (int d = 1; d <= DC; d++) begin
      chk("done_timing", 32'(layer_done_out), (d == DC) ? 32'd1 : 32'd0);
      if (d == DC) begin
        exp_layers++;
        chk("layers_done", 32'(layers_done_out), 32'(exp_layers[15:0]));
        chk("busy_at_done", 32'(busy_out), 32'd1);
      end
      tick();
    end
    chk("done_pulse_len", 32'(layer_done_out), 32'd0);
    chk("busy_after_done", 32'(busy_out), 32'd0);
  endtask

  initial begin
    desc_t d;
    bit    seen;
    logic          m;
    logic [LI-1:0] it;
    logic [LR-1:0] rd;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_cfg",   32'(configure_out), 32'd0);
    chk("rst_busy",  32'(busy_out), 32'd0);
    chk("rst_done",  32'(layer_done_out), 32'd0);
    chk("rst_err",   32'(desc_error_out), 32'd0);
    chk("rst_layers", 32'(layers_done_out), 32'd0);
    chk("rst_avail", 32'(desc_avail_out), 32'd1);
    chk_fields("rst", 1'b0, '0, '0);
    rst = 1'b1;
    tick();

    // ---------------- 1: basic layer ----------------
    launch("t1", 1'b1, 16'd2, 16'd3);
    chk("t1_cfg_pulse", 32'(configure_out), 32'd0);
    chk_fields("t1_hold", 1'b1, 16'd2, 16'd3);
    do_xfers(6, 1'b0);
    expect_done();

    // ---------------- 2: FIFO full, drop third ----------------
    launch("t2a", 1'b0, 16'd3, 16'd2);
    q.delete();
    for (int w = 0; w < 3; w++) begin
      d.m = 1'($urandom_range(0, 1));
      d.i = 16'($urandom_range(1, 3));
      d.r = 16'($urandom_range(1, 3));
      if (q.size() < 2) q.push_back(d);
      write_desc(d.m, d.i, d.r);
      chk("t2_avail", 32'(desc_avail_out), (q.size() < 2) ? 32'd1 : 32'd0);
    end
    do_xfers(6, 1'b1);
    expect_done();
    while (q.size() > 0) begin
      d = q.pop_front();
      chk("t2_cfg_gap", 32'(configure_out), 32'd0);
      tick();
      chk("t2_cfg_b2b", 32'(configure_out), 32'd1);
      chk_fields("t2", d.m, d.i, d.r);
      tick();
      do_xfers(int'(d.i) * int'(d.r), 1'b1);
      expect_done();
    end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      seen |= configure_out;
      tick();
    end
    chk("t2_no_extra_cfg", 32'(seen), 32'd0);
    chk("t2_avail_empty", 32'(desc_avail_out), 32'd1);

    // ---------------- 3: zero-count descriptor ----------------
    write_desc(1'b0, 16'd0, 16'd5);
    chk("t3_err_early", 32'(desc_error_out), 32'd0);
    write_desc(1'b1, 16'd1, 16'd2);
    chk("t3_err", 32'(desc_error_out), 32'd1);
    chk("t3_no_cfg", 32'(configure_out), 32'd0);
    tick();
    chk("t3_err_len", 32'(desc_error_out), 32'd0);
    chk("t3_cfg", 32'(configure_out), 32'd1);
    chk_fields("t3", 1'b1, 16'd1, 16'd2);
    tick();
    do_xfers(2, 1'b1);
    expect_done();
    write_desc(1'b1, 16'd7, 16'd0);
    chk("t3b_err_early", 32'(desc_error_out), 32'd0);
    tick();
    chk("t3b_err", 32'(desc_error_out), 32'd1);
    chk("t3b_no_cfg", 32'(configure_out), 32'd0);
    tick();
    chk("t3b_idle", 32'(busy_out), 32'd0);

    // ---------------- randomized layers ----------------
    for (int n = 0; n < 4; n++) begin
      m  = 1'($urandom_range(0, 1));
      it = 16'($urandom_range(1, 3));
      rd = 16'($urandom_range(1, 4));
      launch("rnd", m, it, rd);
      do_xfers(int'(it) * int'(rd), 1'b1);
      expect_done();
    end

    // ---------------- 4: max counts ----------------
    launch("t4", 1'b0, 16'hFFFF, 16'd1);
    do_xfers(65535, 1'b0);
    expect_done();

    // ---------------- 5: reset mid-RUN ----------------
    launch("t5", 1'b1, 16'd2, 16'd3);
    do_xfers(2, 1'b0);
    write_desc(1'b0, 16'd1, 16'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_cfg",    32'(configure_out), 32'd0);
    chk("t5_busy",   32'(busy_out), 32'd0);
    chk("t5_layers", 32'(layers_done_out), 32'd0);
    chk("t5_avail",  32'(desc_avail_out), 32'd1);
    chk_fields("t5", 1'b0, '0, '0);
    exp_layers = 0;
    xfer_in = 1'b1;
    tick();
    chk("t5_no_done", 32'(layer_done_out), 32'd0);
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      seen |= configure_out | busy_out | layer_done_out;
      tick();
    end
    xfer_in = 1'b0;
    chk("t5_fifo_lost", 32'(seen), 32'd0);
    chk("t5_avail_after", 32'(desc_avail_out), 32'd1);
    chk("t5_layers_after", 32'(layers_done_out), 32'd0);

    // ---------------- 6: stray transfers in IDLE and CONFIG ----------------
    xfer_in = 1'b1;
    tick();
    tick();
    chk("t6_idle_layers", 32'(layers_done_out), 32'd0);
    chk("t6_idle_busy", 32'(busy_out), 32'd0);
    desc_data_in  = {1'b0, 16'd2, 16'd2};
    desc_valid_in = 1'b1;
    tick();
    desc_valid_in = 1'b0;
    tick();
    chk("t6_cfg", 32'(configure_out), 32'd1);
    tick();
    xfer_in = 1'b0;
    do_xfers(4, 1'b0);
    expect_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
